mem_wb_pipe_reg: RTL and testbench

Parametrised MEM/WB pipeline register for the pipelined CPU. It captures memory-stage results on each clock edge and supports stall (hold) and flush (bubble) control. It also carries a valid bit, produces the selected write-back data and the registered destination address for the Forwarding Unit, and counts retired instructions.

---
 rtl/mem_wb_pipe_reg.sv | 90 +++++++++
 tb/tb_mem_wb_pipe_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: stall/flush control, write-back data mux and retired-instruction counter.
// Optional macro MEM_WB_ZERO_REG_GUARD_EN suppresses register-file writes to register 0.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic                  MemToReg_i,
    input  logic                  RegWrite_i,
    input  logic [DATA_W-1:0]     ReadData_i,
    input  logic [DATA_W-1:0]     ALUResult_i,
    input  logic [REG_ADDR_W-1:0] RdAddr_i,
    output logic                  valid_o,
    output logic                  MemToReg_o,
    output logic                  RegWrite_o,
    output logic [DATA_W-1:0]     ReadData_o,
    output logic [DATA_W-1:0]     ALUResult_o,
    output logic [REG_ADDR_W-1:0] RdAddr_o,
    output logic [DATA_W-1:0]     WriteData_o,
    output logic [COUNT_W-1:0]    retired_o
);

    logic                  valid_reg;
    logic                  mem_to_reg_reg;
    logic                  reg_write_reg;
    logic [DATA_W-1:0]     read_data_reg;
    logic [DATA_W-1:0]     alu_result_reg;
    logic [REG_ADDR_W-1:0] rd_addr_reg;
    logic [COUNT_W-1:0]    retired_reg;

    logic                  reg_write_next;
    logic                  retire_fire;

`ifdef MEM_WB_ZERO_REG_GUARD_EN
    // Register 0 is hard-wired, so a write to it must not reach the file or the forwarding unit.
    assign reg_write_next = RegWrite_i & valid_i & (RdAddr_i != '0);
`else
    assign reg_write_next = RegWrite_i & valid_i;
`endif

    // A valid entry leaves the stage whenever it is not held; a flush also pushes it out.
    assign retire_fire = valid_reg & (~stall_i | flush_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_reg      <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            reg_write_reg  <= 1'b0;
            read_data_reg  <= '0;
            alu_result_reg <= '0;
            rd_addr_reg    <= '0;
            retired_reg    <= '0;
        end else begin
            if (retire_fire) begin
                retired_reg <= retired_reg + COUNT_W'(1);
            end

            if (flush_i) begin
                valid_reg      <= 1'b0;
                mem_to_reg_reg <= 1'b0;
                reg_write_reg  <= 1'b0;
                read_data_reg  <= '0;
                alu_result_reg <= '0;
                rd_addr_reg    <= '0;
            end else if (!stall_i) begin
                valid_reg      <= valid_i;
                mem_to_reg_reg <= MemToReg_i;
                reg_write_reg  <= reg_write_next;
                read_data_reg  <= ReadData_i;
                alu_result_reg <= ALUResult_i;
                rd_addr_reg    <= RdAddr_i;
            end
        end
    end

    assign valid_o     = valid_reg;
    assign MemToReg_o  = mem_to_reg_reg;
    assign RegWrite_o  = reg_write_reg;
    assign ReadData_o  = read_data_reg;
    assign ALUResult_o = alu_result_reg;
    assign RdAddr_o    = rd_addr_reg;
    assign retired_o   = retired_reg;
    assign WriteData_o = mem_to_reg_reg ? read_data_reg : alu_result_reg;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: driver pushes expected WB state per edge, monitor pops and compares.
// Honours MEM_WB_ZERO_REG_GUARD_EN in its reference model.
module tb_mem_wb_pipe_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int COUNT_W    = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  stall_i, flush_i, valid_i, MemToReg_i, RegWrite_i;
    logic [DATA_W-1:0]     ReadData_i, ALUResult_i;
    logic [REG_ADDR_W-1:0] RdAddr_i;
    logic                  valid_o, MemToReg_o, RegWrite_o;
    logic [DATA_W-1:0]     ReadData_o, ALUResult_o, WriteData_o;
    logic [REG_ADDR_W-1:0] RdAddr_o;
    logic [COUNT_W-1:0]    retired_o;

    mem_wb_pipe_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .COUNT_W(COUNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .MemToReg_i(MemToReg_i), .RegWrite_i(RegWrite_i),
        .ReadData_i(ReadData_i), .ALUResult_i(ALUResult_i), .RdAddr_i(RdAddr_i),
        .valid_o(valid_o), .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o),
        .ReadData_o(ReadData_o), .ALUResult_o(ALUResult_o), .RdAddr_o(RdAddr_o),
        .WriteData_o(WriteData_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          valid, rw, m2r;
        logic [31:0] rd, alu;
        logic [4:0]  addr;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: the instruction currently sitting in WB plus total retirements.
    bit          m_valid, m_rw, m_m2r;
    logic [31:0] m_rd, m_alu;
    logic [4:0]  m_addr;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s got=0x%08h exp=0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_addr = 0; m_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_o), 0);
        check({tag, "_m2r"},   32'(MemToReg_o), 0);
        check({tag, "_rw"},    32'(RegWrite_o), 0);
        check({tag, "_rdata"}, ReadData_o, 0);
        check({tag, "_alu"},   ALUResult_o, 0);
        check({tag, "_addr"},  32'(RdAddr_o), 0);
        check({tag, "_wdata"}, WriteData_o, 0);
        check({tag, "_ret"},   32'(retired_o), 0);
    endtask

    task automatic step(input bit st, input bit fl, input bit v, input bit m2r, input bit rw,
                        input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] a);
        exp_t e;
        bit   guard_ok;
        stall_i = st; flush_i = fl; valid_i = v; MemToReg_i = m2r; RegWrite_i = rw;
        ReadData_i = rd; ALUResult_i = alu; RdAddr_i = a;
`ifdef MEM_WB_ZERO_REG_GUARD_EN
        guard_ok = (a != 0);
`else
        guard_ok = 1'b1;
`endif
        // The entry in WB retires if it moves on (no stall) or is squashed by a flush.
        if (m_valid && (!st || fl)) m_cnt = (m_cnt + 1) % (1 << COUNT_W);
        if (fl) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_addr = 0;
        end else if (!st) begin
            m_valid = v; m_rw = rw && v && guard_ok; m_m2r = m2r;
            m_rd = rd; m_alu = alu; m_addr = a;
        end
        e.valid = m_valid; e.rw = m_rw; e.m2r = m_m2r; e.rd = m_rd; e.alu = m_alu;
        e.addr = m_addr; e.cnt = m_cnt;
        @(posedge clk_i);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic rand_step();
        step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
             1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)));
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid", 32'(valid_o), 32'(e.valid));
                check("rw",    32'(RegWrite_o), 32'(e.rw));
                check("m2r",   32'(MemToReg_o), 32'(e.m2r));
                check("rdata", ReadData_o, e.rd);
                check("alu",   ALUResult_o, e.alu);
                check("addr",  32'(RdAddr_o), 32'(e.addr));
                check("wdata", WriteData_o, e.m2r ? e.rd : e.alu);
                check("ret",   32'(retired_o), 32'(e.cnt));
                $display("txn t=%0t valid=%0b rw=%0b addr=%0d wdata=%08h ret=%0d",
                         $time, valid_o, RegWrite_o, RdAddr_o, WriteData_o, retired_o);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stall_i = 1; flush_i = 1; valid_i = 1; MemToReg_i = 1; RegWrite_i = 1;
        ReadData_i = '1; ALUResult_i = '1; RdAddr_i = '1;
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        #1 rst_i = 0;

        // Normal flow and write-back mux select
        step(0, 0, 1, 1, 1, 32'hDEADBEEF, 32'h10, 5'd7);
        step(0, 0, 1, 0, 1, 32'hDEADBEEF, 32'h10, 5'd7);
        // Stall holds entry RdAddr=3 for three cycles, then releases
        step(0, 0, 1, 0, 1, 32'h1111, 32'h2222, 5'd3);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, $urandom, $urandom, 5'd9);
        step(0, 0, 1, 1, 1, 32'h3333, 32'h4444, 5'd5);
        // Flush overrides stall
        step(1, 1, 1, 1, 1, 32'h5555, 32'h6666, 5'd6);
        // Invalid entry cannot write and does not retire
        step(0, 0, 0, 0, 1, 32'h7777, 32'h8888, 5'd8);
        step(0, 0, 0, 0, 1, 32'h7777, 32'h8888, 5'd8);
        // Counter wrap over 17 valid entries
        for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 1, $urandom, i, 5'd1);
        // Register-0 destination
        step(0, 0, 1, 0, 1, 32'hA, 32'hB, 5'd0);
        step(0, 0, 1, 1, 1, 32'hC, 32'hD, 5'd2);

        for (int i = 0; i < 400; i++) rand_step();

        // Asynchronous reset between edges while stalling and flushing
        @(negedge clk_i);
        #1;
        stall_i = 1; flush_i = 1;
        rst_i = 1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk_i);
        #1 rst_i = 0;
        for (int i = 0; i < 100; i++) rand_step();

        repeat (3) @(negedge clk_i);
        check("drain", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
